// File: rtl/serial_adder_ctl.sv
// serial_adder_ctl: multi-cycle adder that sums two WIDTH-bit operands plus a
// carry-in, DIGIT bits per clock, LSB digit first, with a start/busy/done
// handshake. The result and carry-out are only updated on the last digit and
// stay held until the next run completes.
module serial_adder_ctl #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;

    logic [DIGIT:0]     w_dig;
    logic [WIDTH-1:0]   w_res_next;

    // Digit adder: low slice of each shifted operand plus the running carry.
    // The result register shifts right so digit 0 lands at the bottom after N steps.
    always_comb begin
        w_dig      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};
        w_res_next = (r_res >> DIGIT)
                   | (WIDTH'(w_dig[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // State register; reset forces IDLE immediately, even mid-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; start is only looked at in IDLE or DONE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == CW'(N - 1)) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, digit-serial shift/accumulate and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_res   <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_res   <= w_res_next;
                r_carry <= w_dig[DIGIT];
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_last) begin
                sum  <= w_res_next;
                cout <= w_dig[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctl.sv
// Directed bench for serial_adder_ctl: three instances (8/1, 8/4, 4/2) share
// clock and reset; vectors come from a table and from a few hand sequences.
module tb_serial_adder_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       start_x1 = 1'b0, start_x4 = 1'b0;
    logic       busy_x1, done_x1, cout_x1, busy_x4, done_x4, cout_x4;
    logic [7:0] sum_x1, sum_x4;

    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0, start_w4 = 1'b0;
    logic       busy_w4, done_w4, cout_w4;
    logic [3:0] sum_w4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder_ctl #(.WIDTH(8), .DIGIT(1)) u_x1 (
        .clk(clk), .rst(rst), .start(start_x1), .a(a8), .b(b8), .cin(cin8),
        .busy(busy_x1), .done(done_x1), .sum(sum_x1), .cout(cout_x1));

    serial_adder_ctl #(.WIDTH(8), .DIGIT(4)) u_x4 (
        .clk(clk), .rst(rst), .start(start_x4), .a(a8), .b(b8), .cin(cin8),
        .busy(busy_x4), .done(done_x4), .sum(sum_x4), .cout(cout_x4));

    serial_adder_ctl #(.WIDTH(4), .DIGIT(2)) u_w4 (
        .clk(clk), .rst(rst), .start(start_w4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy_w4), .done(done_w4), .sum(sum_w4), .cout(cout_w4));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // busy and done must never be high together on any instance
    always @(negedge clk) begin
        if (!rst && ((busy_x1 && done_x1) || (busy_x4 && done_x4) || (busy_w4 && done_w4))) begin
            tests++;
            fails++;
            $display("FAIL busy_and_done: both high at %0t", $time);
        end
    end

    // One 8-bit transaction on u_x1 (sel=0) or u_x4 (sel=1).
    task automatic run8(input bit sel, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, output logic [7:0] s, output logic c,
                        output int lat, output int bc);
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc;
        if (sel) start_x4 = 1'b1; else start_x1 = 1'b1;
        @(posedge clk); #1;
        start_x1 = 1'b0; start_x4 = 1'b0;
        bc  = (sel ? busy_x4 : busy_x1) ? 1 : 0;
        lat = 0;
        while (!(sel ? done_x4 : done_x1) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (sel ? busy_x4 : busy_x1) bc++;
        end
        s = sel ? sum_x4 : sum_x1;
        c = sel ? cout_x4 : cout_x1;
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                        output logic [3:0] s, output logic c, output int lat);
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tc; start_w4 = 1'b1;
        @(posedge clk); #1;
        start_w4 = 1'b0;
        lat = 0;
        while (!done_w4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum_w4;
        c = cout_w4;
    endtask

    initial begin
        logic [7:0] s8;
        logic [3:0] s4;
        logic       c;
        int         lat, bc, ndone, d1k, d2k, errs;
        logic [7:0] ds1, ds2;
        logic       dc1, dc2, prev_done, wide;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        tbl[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        tbl[7] = '{8'h80, 8'h81, 1'b0, 8'h01, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_x1, 0);
        chk("rst_done", done_x1, 0);
        chk("rst_sum",  sum_x1,  0);
        chk("rst_cout", cout_x1, 0);
        @(negedge clk);
        rst = 1'b0;

        // table vectors, DIGIT=1
        for (int i = 0; i < 8; i++) begin
            run8(1'b0, tbl[i].a, tbl[i].b, tbl[i].cin, s8, c, lat, bc);
            chk($sformatf("x1_sum[%0d]", i), s8, tbl[i].s);
            chk($sformatf("x1_cout[%0d]", i), c, tbl[i].c);
            chk($sformatf("x1_lat[%0d]", i), lat, 8);
            chk($sformatf("x1_busy[%0d]", i), bc, 8);
        end

        // DIGIT=4: two edges per result
        run8(1'b1, 8'h9A, 8'h77, 1'b0, s8, c, lat, bc);
        chk("x4_sum", s8, 8'h11);
        chk("x4_cout", c, 1);
        chk("x4_lat", lat, 2);
        chk("x4_busy", bc, 2);
        run8(1'b1, 8'h0F, 8'h01, 1'b0, s8, c, lat, bc);
        chk("x4_sum_carry", s8, 8'h10);
        chk("x4_cout_carry", c, 0);

        // start held high, operands scrambled during RUN, back-to-back second run
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start_x1 = 1'b1;
        @(posedge clk); #1;
        ndone = 0; d1k = -1; d2k = -1; prev_done = 1'b0; wide = 1'b0;
        ds1 = '0; ds2 = '0; dc1 = 1'b0; dc2 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_x1 && ndone == 1) begin
                a8 = 8'h21; b8 = 8'h43; cin8 = 1'b0;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                if (ndone >= 2) start_x1 = 1'b0;
            end
            @(posedge clk); #1;
            if (done_x1) begin
                ndone++;
                if (prev_done) wide = 1'b1;
                if (ndone == 1) begin d1k = k; ds1 = sum_x1; dc1 = cout_x1; end
                if (ndone == 2) begin d2k = k; ds2 = sum_x1; dc2 = cout_x1; end
            end
            prev_done = done_x1;
        end
        start_x1 = 1'b0;
        chk("b2b_ndone", ndone, 2);
        chk("b2b_first_at", d1k, 7);
        chk("b2b_second_at", d2k, 16);
        chk("b2b_sum1", ds1, 8'h10);
        chk("b2b_cout1", dc1, 0);
        chk("b2b_sum2", ds2, 8'h64);
        chk("b2b_cout2", dc2, 0);
        chk("b2b_pulse_wide", wide, 0);
        chk("hold_sum", sum_x1, 8'h64);
        chk("hold_busy", busy_x1, 0);

        // async reset mid-run (counter=3); last result is nonzero with carry
        run8(1'b0, 8'h80, 8'h81, 1'b0, s8, c, lat, bc);
        chk("pre_rst_sum", s8, 8'h01);
        chk("pre_rst_cout", c, 1);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start_x1 = 1'b1;
        @(posedge clk); #1;
        start_x1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy_x1, 0);
        chk("arst_done", done_x1, 0);
        chk("arst_sum",  sum_x1,  0);
        chk("arst_cout", cout_x1, 0);
        @(negedge clk);
        rst = 1'b0;
        run8(1'b0, 8'h01, 8'h02, 1'b0, s8, c, lat, bc);
        chk("post_rst_sum", s8, 8'h03);
        chk("post_rst_cout", c, 0);
        chk("post_rst_lat", lat, 8);

        // exhaustive WIDTH=4, DIGIT=2
        errs = fails;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run4(4'(ia), 4'(ib), 1'(ic), s4, c, lat);
                    chk($sformatf("w4_%0h+%0h+%0d", ia, ib, ic), {c, s4}, ia + ib + ic);
                    chk($sformatf("w4_lat_%0h+%0h+%0d", ia, ib, ic), lat, 2);
                end
            end
        end
        $display("exhaustive sweep: %0d errors", fails - errs);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
